// File: rtl/sid_envelope_if.sv
// sid_envelope_if: phi2-paced ADSR control inputs and registered envelope outputs of one SID voice
interface sid_envelope_if;
    logic       phi2_en;
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] release_rate;
    logic [7:0] envelope;
    logic [1:0] state_o;
    modport master (
        output phi2_en, gate, attack, decay, sustain, release_rate,
        input  envelope, state_o
    );
    modport slave (
        input  phi2_en, gate, attack, decay, sustain, release_rate,
        output envelope, state_o
    );
endinterface

// File: rtl/sid_envelope.sv
// sid_envelope: MOS6581/8580 ADSR envelope generator, advanced once per phi2 enable
module sid_envelope #(
    parameter int RATE_BITS = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    sid_envelope_if.slave bus
);
    typedef enum logic [1:0] {ATTACK = 2'd0, DECAY_SUSTAIN = 2'd1, RELEASE = 2'd2} state_t;
    localparam logic [15:0] PERIODS [16] = '{
        16'd9, 16'd32, 16'd63, 16'd95, 16'd149, 16'd220, 16'd267, 16'd313,
        16'd392, 16'd977, 16'd1954, 16'd3126, 16'd3907, 16'd11720, 16'd19532, 16'd31251
    };
    state_t               state, state_n, state_g;
    logic [7:0]           env, env_n;
    logic                 hold_zero, hold_zero_n, gate_prev, gate_prev_n;
    logic                 rise, fall, rate_step, exp_hit;
    logic [RATE_BITS-1:0] rate_cnt, rate_cnt_n, rate_nx, period;
    logic [4:0]           exp_cnt, exp_cnt_n, exp_period, exp_period_n;
    logic [3:0]           rate_idx;
    assign rise      = bus.gate & ~gate_prev;
    assign fall      = ~bus.gate & gate_prev;
    assign state_g   = rise ? ATTACK : fall ? RELEASE : state;
    assign rate_idx  = state_g == ATTACK ? bus.attack : state_g == DECAY_SUSTAIN ? bus.decay : bus.release_rate;
    assign period    = RATE_BITS'(PERIODS[rate_idx]);
    // The counter wraps instead of clearing, so a period below rate_cnt waits a full wrap
    assign rate_nx   = rate_cnt + 1'b1;
    assign rate_step = rate_nx == period;
    assign exp_hit   = exp_cnt + 5'd1 == exp_period;
    always_comb begin
        state_n      = state;
        env_n        = env;
        hold_zero_n  = hold_zero;
        gate_prev_n  = gate_prev;
        rate_cnt_n   = rate_cnt;
        exp_cnt_n    = exp_cnt;
        exp_period_n = exp_period;
        if (bus.phi2_en) begin
            state_n     = state_g;
            hold_zero_n = hold_zero & ~rise;
            gate_prev_n = bus.gate;
            rate_cnt_n  = rate_step ? '0 : rate_nx;
            if (rate_step && state_g == ATTACK) begin
                exp_cnt_n = '0;
                env_n     = env + 8'd1;
                state_n   = env_n == 8'hff ? DECAY_SUSTAIN : ATTACK;
            end else if (rate_step) begin
                exp_cnt_n = exp_hit ? '0 : exp_cnt + 5'd1;
                if (exp_hit && !hold_zero_n && (state_g == RELEASE || env != {bus.sustain, bus.sustain})) begin
                    env_n       = env - 8'd1;
                    hold_zero_n = env_n == 8'h00;
                end
            end
            exp_period_n = env_n == 8'hff ? 5'd1  :
                           env_n == 8'h5d ? 5'd2  :
                           env_n == 8'h36 ? 5'd4  :
                           env_n == 8'h1a ? 5'd8  :
                           env_n == 8'h0e ? 5'd16 :
                           env_n == 8'h06 ? 5'd30 :
                           env_n == 8'h00 ? 5'd1  : exp_period;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RELEASE;
            env        <= 8'h00;
            hold_zero  <= 1'b1;
            gate_prev  <= 1'b0;
            rate_cnt   <= '0;
            exp_cnt    <= '0;
            exp_period <= 5'd1;
        end else begin
            state      <= state_n;
            env        <= env_n;
            hold_zero  <= hold_zero_n;
            gate_prev  <= gate_prev_n;
            rate_cnt   <= rate_cnt_n;
            exp_cnt    <= exp_cnt_n;
            exp_period <= exp_period_n;
        end
    end
    assign bus.envelope = env;
    assign bus.state_o  = state;
endmodule
